// File: rtl/daq_link_buffer.sv
// Store-and-forward DAQ frame buffer: admits whole frames only when MAX_FRAME words are free,
// and presents words on the link only after the frame's trailer has been stored.
module daq_link_buffer #(
   parameter int AW        = 11,
   parameter int MAX_FRAME = 900,
   parameter int FCW       = 8
) (
   input  logic           clk,
   input  logic           hard_rst,
   input  logic [18:0]    daqp,
   input  logic           clr_err,
   output logic [17:0]    dout,
   output logic           dout_valid,
   input  logic           dout_ready,
   output logic           dout_last,
   output logic [FCW-1:0] frames_pending,
   output logic [AW:0]    fifo_words,
   output logic [15:0]    frames_dropped,
   output logic           err_proto
);

   localparam logic [18:0] HDR   = 19'h0DB0A;
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] MAXF  = (AW+1)'(MAX_FRAME);

   typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_DISCARD} wstate_t;

   wstate_t       state, state_nxt;
   logic [18:0]   mem [0:(1<<AW)-1];
   logic [AW-1:0] wr_ptr, rd_ptr, cm_ptr;
   logic          wr_en, commit, commit_d, err_set, drop;
   logic          word_ok, is_hdr, is_trl, full, rd, fetch;
   logic [AW:0]   free;

   assign word_ok = ~daqp[18];
   assign is_hdr  = (daqp == HDR);
   assign is_trl  = word_ok && (daqp[18:11] == 8'h3A);
   assign full    = (fifo_words == DEPTH);
   assign free    = DEPTH - fifo_words;
   assign rd      = dout_valid && dout_ready;
   // Only words up to the last committed trailer are ever prefetched into dout.
   assign fetch   = (rd_ptr != cm_ptr) && (!dout_valid || rd);

   always_ff @(posedge clk or negedge hard_rst) begin
      if (!hard_rst) state <= W_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      commit    = 1'b0;
      err_set   = 1'b0;
      drop      = 1'b0;
      if (word_ok) begin
         case (state)
            W_IDLE: begin
               if (is_hdr) begin
                  if (free >= MAXF) begin
                     wr_en     = 1'b1;
                     state_nxt = W_ACCEPT;
                  end else begin
                     drop      = 1'b1;
                     state_nxt = W_DISCARD;
                  end
               end else begin
                  err_set = 1'b1;
               end
            end
            W_ACCEPT: begin
               if (full) begin
                  err_set = 1'b1;
               end else begin
                  wr_en = 1'b1;
                  if (is_hdr) err_set = 1'b1;
                  if (is_trl) begin
                     commit    = 1'b1;
                     state_nxt = W_IDLE;
                  end
               end
            end
            W_DISCARD: if (is_trl) state_nxt = W_IDLE;
            default:   state_nxt = W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {is_trl, daqp[17:0]};
   end

   always_ff @(posedge clk or negedge hard_rst) begin
      if (!hard_rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         cm_ptr         <= '0;
         commit_d       <= 1'b0;
         dout           <= '0;
         dout_last      <= 1'b0;
         dout_valid     <= 1'b0;
         frames_pending <= '0;
         fifo_words     <= '0;
         frames_dropped <= '0;
         err_proto      <= 1'b0;
      end else begin
         if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
         if (commit) cm_ptr <= wr_ptr + 1'b1;
         // Delayed so frames_pending rises together with dout_valid.
         commit_d <= commit;

         if (fetch) begin
            {dout_last, dout} <= mem[rd_ptr];
            rd_ptr            <= rd_ptr + 1'b1;
            dout_valid        <= 1'b1;
         end else if (rd) begin
            dout_valid <= 1'b0;
         end

         case ({commit_d, rd && dout_last})
            2'b10:   frames_pending <= frames_pending + 1'b1;
            2'b01:   frames_pending <= frames_pending - 1'b1;
            default: ;
         endcase

         case ({wr_en, rd})
            2'b10:   fifo_words <= fifo_words + 1'b1;
            2'b01:   fifo_words <= fifo_words - 1'b1;
            default: ;
         endcase

         if (err_set)      err_proto <= 1'b1;
         else if (clr_err) err_proto <= 1'b0;

         // A drop in the clearing cycle still counts as one.
         if (drop) begin
            if (clr_err)                       frames_dropped <= 16'd1;
            else if (frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 1'b1;
         end else if (clr_err) begin
            frames_dropped <= '0;
         end
      end
   end

endmodule

// File: tb/tb_daq_link_buffer.sv
// Directed + randomized bench for daq_link_buffer; frame-level queue model scores the link output.
module tb_daq_link_buffer;
   localparam int AW = 11, MAXF = 900, FCW = 8, DEPTH = 2048;
   localparam logic [18:0] HDR = 19'h0DB0A;

   logic           clk = 1'b0, hard_rst = 1'b0, clr_err = 1'b0, dout_ready = 1'b0;
   logic [18:0]    daqp = 19'h40000;
   logic [17:0]    dout;
   logic           dout_valid, dout_last, err_proto;
   logic [FCW-1:0] frames_pending;
   logic [AW:0]    fifo_words;
   logic [15:0]    frames_dropped;

   always #5 clk = ~clk;

   daq_link_buffer #(.AW(AW), .MAX_FRAME(MAXF), .FCW(FCW)) dut (
      .clk(clk), .hard_rst(hard_rst), .daqp(daqp), .clr_err(clr_err),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
      .frames_pending(frames_pending), .fifo_words(fifo_words),
      .frames_dropped(frames_dropped), .err_proto(err_proto));

   int n_cmp = 0, n_err = 0;
   logic [18:0] expq[$];
   logic [18:0] frm[$];
   int wr_cnt = 0, rd_cnt = 0, pend_m = 0, mode = 0, drop_m = 0;
   logic err_m = 1'b0;
   bit chk_pend = 0, rand_ready = 0;
   logic prev_stall = 1'b0;
   logic [17:0] prev_dout = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [18:0] rnd_data();
      logic [18:0] d;
      do d = 19'($urandom) & 19'h3FFFF; while (d[18:11] == 8'h3A || d == HDR);
      return d;
   endfunction

   function automatic logic [18:0] rnd_trl();
      logic [18:0] t;
      t = {8'h3A, 11'($urandom)};
      return t;
   endfunction

   // Drive one upstream word and apply the frame rules to the model.
   task automatic send(input logic [18:0] w);
      int cnt;
      bit hdr, trl;
      @(posedge clk); #1;
      daqp = w;
      if (rand_ready) dout_ready = 1'($urandom);
      if (!w[18]) begin
         cnt = wr_cnt - rd_cnt;
         hdr = (w == HDR);
         trl = (w[18:11] == 8'h3A);
         if (mode == 0) begin
            if (hdr && (DEPTH - cnt) >= MAXF) begin
               frm.push_back({1'b0, w[17:0]}); wr_cnt++; mode = 1;
            end else if (hdr) begin
               if (drop_m < 65535) drop_m++;
               mode = 2;
            end else err_m = 1'b1;
         end else if (mode == 1) begin
            if (cnt == DEPTH) err_m = 1'b1;
            else begin
               wr_cnt++;
               frm.push_back({trl, w[17:0]});
               if (hdr) err_m = 1'b1;
               if (trl) begin
                  foreach (frm[i]) expq.push_back(frm[i]);
                  frm.delete();
                  pend_m++;
                  mode = 0;
               end
            end
         end else if (trl) mode = 0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) send(19'h40000 | 19'($urandom));
   endtask

   task automatic send_frame(input int ndata);
      send(HDR);
      repeat (ndata) send(rnd_data());
      send(rnd_trl());
   endtask

   task automatic wait_drain();
      int k = 0;
      while ((expq.size() != 0 || dout_valid) && k < 5000) begin idle(1); k++; end
      chk("drain_in_time", 32'(k < 5000), 1);
      idle(3);
   endtask

   task automatic quiet(input string tag);
      chk({tag, "_words"},   fifo_words, wr_cnt - rd_cnt);
      chk({tag, "_pending"}, frames_pending, pend_m);
      chk({tag, "_err"},     err_proto, err_m);
      chk({tag, "_dropped"}, frames_dropped, drop_m);
   endtask

   task automatic clr();
      @(posedge clk); #1;
      clr_err = 1'b1; daqp = 19'h40000;
      err_m = 1'b0; drop_m = 0;
      @(posedge clk); #1;
      clr_err = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk); #1;
      hard_rst = 1'b0; daqp = 19'h40000;
      #1;
      chk({tag, "_dout"},    dout, 0);
      chk({tag, "_valid"},   dout_valid, 0);
      chk({tag, "_last"},    dout_last, 0);
      chk({tag, "_pending"}, frames_pending, 0);
      chk({tag, "_words"},   fifo_words, 0);
      chk({tag, "_dropped"}, frames_dropped, 0);
      chk({tag, "_err"},     err_proto, 0);
      expq.delete(); frm.delete();
      wr_cnt = 0; rd_cnt = 0; pend_m = 0; mode = 0; err_m = 1'b0; drop_m = 0;
      @(posedge clk); #1;
      hard_rst = 1'b1;
   endtask

   // Link-side scoreboard: every accepted read must match the next stored word.
   always @(negedge clk) begin
      logic [18:0] e;
      if (!hard_rst) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            chk("stall_valid", dout_valid, 1);
            chk("stall_dout", dout, prev_dout);
         end
         if (dout_valid && dout_ready) begin
            if (expq.size() == 0) chk("read_unexpected", 1, 0);
            else begin
               e = expq.pop_front();
               chk("read_word", {dout_last, dout}, e);
            end
            if (dout_last && chk_pend) chk("pend_at_trl", frames_pending, pend_m);
            if (dout_last) pend_m--;
            rd_cnt++;
         end
         prev_stall = dout_valid && !dout_ready;
         prev_dout  = dout;
      end
   end

   initial begin
      int n0, total;
      // reset state
      #2;
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_last", dout_last, 0);
      chk("rst_pending", frames_pending, 0);
      chk("rst_words", fifo_words, 0);
      chk("rst_dropped", frames_dropped, 0);
      chk("rst_err", err_proto, 0);
      @(posedge clk); #1 hard_rst = 1'b1;

      // single frame, latency and order
      dout_ready = 1'b1;
      send_frame(10);
      @(negedge clk) chk("t1_lat0", dout_valid, 0);
      idle(1);
      @(negedge clk) chk("t1_lat1", dout_valid, 0);
      chk("t1_pend_lat1", frames_pending, 0);
      idle(1);
      @(negedge clk) chk("t1_lat2", dout_valid, 1);
      chk("t1_pend_lat2", frames_pending, 1);
      wait_drain();
      chk("t1_nwords", rd_cnt, 12);
      quiet("t1");

      // three frames held, then contiguous drain
      dout_ready = 1'b0;
      for (int f = 0; f < 3; f++) send_frame($urandom_range(0, 15));
      idle(3);
      quiet("t2_held");
      chk("t2_pend3", frames_pending, 3);
      chk_pend = 1;
      n0 = rd_cnt; total = wr_cnt - rd_cnt;
      dout_ready = 1'b1;
      idle(total);
      chk("t2_contig", rd_cnt - n0, total);
      chk_pend = 0;
      idle(3);
      quiet("t2");

      // drop when free = MAX_FRAME-1
      dout_ready = 1'b0;
      send_frame(DEPTH - MAXF + 1 - 2);
      idle(2);
      chk("t3_fill", fifo_words, DEPTH - MAXF + 1);
      send_frame(5);
      idle(2);
      quiet("t3_drop");
      chk("t3_dropped1", frames_dropped, 1);
      dout_ready = 1'b1;
      wait_drain();
      send_frame(7);
      wait_drain();
      quiet("t3_after");

      // stray words and clr_err
      send(rnd_data());
      send(rnd_trl());
      idle(2);
      quiet("t4_stray");
      chk("t4_err1", err_proto, 1);
      clr();
      idle(1);
      quiet("t4_clr");

      // oversize frame overruns the FIFO
      dout_ready = 1'b0;
      send_frame(10);
      send(HDR);
      repeat (DEPTH) send(rnd_data());
      send(rnd_trl());
      idle(2);
      quiet("t5_full");
      chk("t5_full_words", fifo_words, DEPTH);
      dout_ready = 1'b1;
      wait_drain();
      quiet("t5_drained");

      // reset mid-frame, then mid-drain
      do_reset("t6_rst_a");
      dout_ready = 1'b0;
      send_frame(6);
      send_frame(9);
      dout_ready = 1'b1;
      idle(3);
      send(HDR); send(rnd_data()); send(rnd_data());
      do_reset("t6_rst_b");
      repeat (3) send(rnd_data());
      idle(2);
      quiet("t6_stray");
      clr();
      send_frame(8);
      wait_drain();
      quiet("t6_clean");

      // randomized traffic with random link backpressure
      rand_ready = 1;
      for (int f = 0; f < 20; f++) begin
         if ($urandom_range(0, 7) == 0) send(rnd_data());
         send(HDR);
         repeat ($urandom_range(0, 25)) begin
            if ($urandom_range(0, 39) == 0) send(HDR);
            else send(rnd_data());
         end
         send(rnd_trl());
         idle($urandom_range(0, 3));
      end
      rand_ready = 0;
      dout_ready = 1'b1;
      wait_drain();
      quiet("t7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
